// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller: instruction field
// slices, SPECIAL-opcode function codes and the issue FSM state type.
package md_issue_ctrl_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;

  localparam logic [5:0] FuncMfhi  = 6'h10;
  localparam logic [5:0] FuncMthi  = 6'h11;
  localparam logic [5:0] FuncMflo  = 6'h12;
  localparam logic [5:0] FuncMtlo  = 6'h13;
  localparam logic [5:0] FuncMult  = 6'h18;
  localparam logic [5:0] FuncMultu = 6'h19;
  localparam logic [5:0] FuncDiv   = 6'h1A;
  localparam logic [5:0] FuncDivu  = 6'h1B;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StBusy
  } md_state_e;

  function automatic logic [5:0] op_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] func_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational classifier: flags MD-unit operations and any HI/LO user.
module md_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_md,
  output logic        is_hilo
);

  logic [5:0] op;
  logic [5:0] func;
  logic       unused_mid;

  assign op         = op_of(instr);
  assign func       = func_of(instr);
  assign unused_mid = ^instr[25:6];

  // Decode function field of SPECIAL-opcode instructions.
  always_comb begin
    is_md   = 1'b0;
    is_hilo = 1'b0;
    if (op == OpSpecial) begin
      case (func)
        FuncMult, FuncMultu, FuncDiv, FuncDivu: begin
          is_md   = 1'b1;
          is_hilo = 1'b1;
        end
        FuncMfhi, FuncMthi, FuncMflo, FuncMtlo: is_hilo = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit: issues exactly one start per
// MD instruction, stalls D-stage HI/LO users while an operation is in flight,
// and supervises the operation with a watchdog and a stall-cycle counter.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  input  logic [31:0]      instr_e,
  input  logic             valid_e,
  input  logic             e_new,
  input  logic             busy,
  input  logic             req,
  output logic             start,
  output logic             stall_d,
  output logic             md_inflight,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned    WdW    = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic             issued_q, issued_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic d_is_hilo, d_is_md_unused;
  logic e_is_md, e_is_hilo_unused;

  md_decode u_dec_d (
    .instr   (instr_d),
    .is_md   (d_is_md_unused),
    .is_hilo (d_is_hilo)
  );

  md_decode u_dec_e (
    .instr   (instr_e),
    .is_md   (e_is_md),
    .is_hilo (e_is_hilo_unused)
  );

  // Handshake outputs. In-flight ends in the cycle busy drops so a waiting
  // HI/LO reader is released exactly when the result becomes visible.
  always_comb begin
    start = ~reset & valid_e & e_is_md & ~issued_q & ~req & ~busy & (state_q == StIdle);
    md_inflight = start | (state_q == StWaitBusy) | ((state_q == StBusy) & busy);
    stall_d     = ~reset & d_is_hilo & (md_inflight | busy);
  end

  assign err_timeout  = err_q;
  assign stall_cycles = cnt_q;

  // Next-state: FSM, watchdog, issued flag and saturating stall counter.
  always_comb begin
    state_d  = state_q;
    wd_d     = '0;
    err_d    = err_q;
    issued_d = issued_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle:     if (start) state_d = StWaitBusy;
      StWaitBusy: begin
        if (busy)     state_d = StBusy;
        else if (req) state_d = StIdle;
      end
      StBusy:     if (!busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      if (wd_q == WdLast) begin
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end

    // A newly loaded E instruction always starts un-issued.
    if (e_new)      issued_d = 1'b0;
    else if (start) issued_d = 1'b1;

    if (stall_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      issued_q <= 1'b0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
